// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
//   Memory-side responder for the core's data-memory request port. Accepts one
//   load/store at a time, waits WAIT_STATES cycles, then executes the access
//   in a single edge and returns a one-cycle ready pulse with extended load
//   data or an error flag.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined     -> misaligned H/HU/W accesses return mem_err_o=1 and no access.
//   not defined -> low address bits below the access width are ignored.
//
// Ports
//   clk_i        clock, all state updates on posedge
//   reset        synchronous active-high reset
//   mem_req_i    request valid
//   mem_we_i     1 = store, 0 = load
//   mem_size_i   000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//   mem_addr_i   byte address
//   mem_wd_i     store data, right-aligned
//   mem_rd_o     load data (extended), zero unless mem_ready_o
//   mem_ready_o  one-cycle response pulse
//   mem_err_o    error flag, qualified by mem_ready_o
//   mem_busy_o   high while a request is outstanding (WAIT, RESP)
//   stall_o      combinational mem_req_i & ~mem_ready_o
module riscv_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        mem_busy_o,
  output logic        stall_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  req_t              req_in;
  req_t              ex;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [31:0]       rd_q, rd_d;
  logic              exec;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              in_win;
  logic              size_ok;
  logic              misalign;
  logic              ex_err;
  logic [31:0]       word;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_val;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              wr_en;

  assign req_in = '{we: mem_we_i, size: mem_size_i, addr: mem_addr_i, wd: mem_wd_i};

  // In WAIT the captured request executes; otherwise a zero-wait accept uses the live inputs.
  assign ex = (state_q == S_WAIT) ? req_q : req_in;

  // Address decode and window check (33-bit so the upper bound cannot wrap).
  always_comb begin
    offset  = ex.addr - BASE_ADDR;
    idx     = IDX_W'(offset >> 2);
    in_win  = ({1'b0, ex.addr} >= {1'b0, BASE_ADDR}) &&
              ({1'b0, ex.addr} < ({1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4));
    size_ok = 1'b0;
    case (ex.size)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
      default:                                size_ok = 1'b0;
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((ex.size[1:0] == 2'b01) && ex.addr[0]) ||
               ((ex.size[1:0] == 2'b10) && (ex.addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    ex_err = ~in_win | ~size_ok | misalign;
  end

  // Load lane selection and extension.
  always_comb begin
    word   = mem[idx];
    ld_b   = 8'(word >> {ex.addr[1:0], 3'b000});
    ld_h   = 16'(word >> {ex.addr[1], 4'b0000});
    ld_val = word;
    case (ex.size)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_val = {24'h0, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_val = {16'h0, ld_h};
      default: ld_val = word;
    endcase
  end

  // Store byte enables; data is replicated so every enabled lane sees the right bytes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = ex.wd;
    case (ex.size[1:0])
      2'b00: begin
        st_be   = 4'b0001 << ex.addr[1:0];
        st_data = {4{ex.wd[7:0]}};
      end
      2'b01: begin
        st_be   = ex.addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{ex.wd[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = ex.wd;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rd_d    = 32'h0;
    exec    = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (mem_req_i) begin
          req_d = req_in;
          if (WAIT_STATES == 0) begin
            exec    = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          exec    = 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (exec) begin
      ready_d = 1'b1;
      err_d   = ex_err;
      rd_d    = (ex_err || ex.we) ? 32'h0 : ld_val;
      wr_en   = ~ex_err & ex.we;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
    end
  end

  // Storage is never cleared; a reset edge suppresses the pending write.
  always_ff @(posedge clk_i) begin
    if (wr_en && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign mem_rd_o    = rd_q;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;
  assign mem_busy_o  = busy_q;
  assign stall_o     = mem_req_i & ~ready_q;

endmodule
